lsu_rmw: RTL and testbench
==========================

# lsu_rmw

Sequential load/store unit between the CPU memory stage and a word-organised, single-port, synchronous-read data memory. It generalises the combinational byte/halfword load-extract and store-merge path in three ways:
- it takes requests on a valid/ready handshake;
- it performs read-modify-write for sub-word stores;
- it splits misaligned accesses that cross a word boundary into two word accesses.

The address width and misalignment support are parametrised.

## Interface
- ADDR_W, 32, byte-address width; memory word address is ADDR_W-2 bits.
- MISALIGN_EN, 1, 1: misaligned accesses are split/merged in hardware; 0: misaligned accesses return an error.

Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.

Request side:
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  4  encoding: LB=0, LH=1, LW=2, LBU=3, LHU=4, SB=5, SH=6, SW=7; 8–15 are invalid.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.

Response side:
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load result, sign- or zero-extended; 0 for stores and errors.
- resp_err  out  1  misaligned access with MISALIGN_EN=0, or invalid op.

Memory side:
- mem_addr  out  ADDR_W-2  word address.
- mem_re  out  1  read strobe; data is returned on mem_rdata the next cycle.
- mem_rdata  in  32  read data.
- mem_we  out  1  full-word write, committed at the clk edge.
- mem_wdata  out  32  write data.

## Operation
Request capture:
- On req_valid && req_ready, register op, addr, wdata. Later changes on the req_* inputs have no effect.

Address and size:
- off = addr[1:0]; w0 = addr[ADDR_W-1:2]; w1 = w0+1, wrapping modulo 2^(ADDR_W-2).
- size = 1 for B/BU, 2 for H/HU, 4 for W.
- misaligned: size 2 with off[0]=1, or size 4 with off≠0.
- span = (off+size > 4).

Load data path:
- Form {hi,lo}. hi = word w1 if span, else 0.
- Shift right by 8·off, keep size bytes.
- Sign-extend for LB/LH; zero-extend for LBU/LHU.

Store data path:
- Replace bytes off..off+size-1 of {hi,lo} with the low size bytes of wdata.
- Bytes outside that range keep the values read from memory.

State machine (all memory outputs are decoded from the state and the registered request):
- IDLE: req_ready=1. On accept:
  - invalid op, or misaligned with MISALIGN_EN=0 → RESP with err set;
  - SW with off=0 → WR0;
  - otherwise → RD0.
- RD0: mem_re=1, mem_addr=w0. Next state is RD1 if span, else CAP.
- RD1: mem_re=1, mem_addr=w1; lo←mem_rdata. Next state CAP.
- CAP: capture mem_rdata into hi if span, else into lo. Next state is RESP for loads, WR0 for stores.
- WR0: mem_we=1, mem_addr=w0, mem_wdata=merged lo. Next state is WR1 if span, else RESP.
- WR1: mem_we=1, mem_addr=w1, mem_wdata=merged hi. Next state RESP.
- RESP: resp_valid=1 with registered resp_rdata/resp_err. Next state IDLE.

Output rules:
- mem_re and mem_we are never high in the same cycle.
- mem_re, mem_we and resp_valid are 0 in every state not listed for them.
- resp_rdata and resp_err hold their values after RESP until the next RESP.

## Timing
Reset:
- Asserting rst forces IDLE immediately, without waiting for a clock edge.
- During and after reset: req_ready=1; resp_valid, resp_err, mem_re, mem_we = 0; resp_rdata, mem_addr, mem_wdata = 0.

Latency, measured as cycles from the accept edge to the resp_valid cycle:
- error: 1.
- aligned SW: 2.
- non-spanning load: 3.
- spanning load: 4.
- non-spanning sub-word/misaligned store: 4.
- spanning store: 6.

Throughput and response:
- One request in flight.
- The next accept is possible in the cycle after RESP.
- resp_valid lasts exactly one cycle; there is no backpressure on the response.

Reset mid-operation:
- The operation is aborted with no response.
- If reset lands in WR1, the word-w0 write already committed stays committed; this is accepted behaviour.

Address wrap: the w1 access at the top word address goes to word 0.

## Test plan
Preload mem[0]=0x44332211 and mem[1]=0x88776655 for all scenarios.
- Sub-word loads:
  - LB at addr 3 → resp_rdata=0x00000044, 3 cycles after accept.
  - LB at addr 7 → 0xFFFFFF88.
  - LHU at addr 1 → 0x00003322, no second read.
- Spanning load: LW at addr 1 → mem_re on word 0 then word 1 in consecutive cycles; resp_rdata=0x55443322 at latency 4.
- Spanning store: SH at addr 3, wdata 0x1234BEEF → mem[0]=0xEF332211, mem[1]=0x887766BE; two writes; resp_valid at latency 6 with resp_rdata=0.
- Aligned store: SW at addr 4, wdata 0xDEADBEEF → no mem_re, one write mem[1]=0xDEADBEEF, latency 2.
- Errors:
  - MISALIGN_EN=0, LW at addr 2 → resp_err=1 and resp_rdata=0 at latency 1, with no mem_re/mem_we.
  - op=4'hF → resp_err=1.
- Reset and wrap:
  - Assert rst during WR1 of a spanning SW → mem_we falls without waiting for a clock edge, req_ready=1, no resp_valid, mem[w0] already updated.
  - LH at addr 0xFFFFFFFF → mem_addr 0x3FFFFFFF then 0x00000000.

Source files
------------

// File: rtl/lsu_rmw.sv
// Sequential load/store unit: valid/ready request capture, read-modify-write for
// sub-word stores and two-word split of misaligned accesses that cross a word boundary.
module lsu_rmw #(
    parameter int unsigned ADDR_W      = 32,
    parameter bit          MISALIGN_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata
);

    localparam int unsigned WA_W = ADDR_W - 2;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD0  = 3'd1;
    localparam logic [2:0] RD1  = 3'd2;
    localparam logic [2:0] CAP  = 3'd3;
    localparam logic [2:0] WR0  = 3'd4;
    localparam logic [2:0] WR1  = 3'd5;
    localparam logic [2:0] RESP = 3'd6;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LH  = 4'd1;
    localparam logic [3:0] OP_LW  = 4'd2;
    localparam logic [3:0] OP_LBU = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_SB  = 4'd5;
    localparam logic [3:0] OP_SH  = 4'd6;
    localparam logic [3:0] OP_SW  = 4'd7;

    logic [2:0]        state, state_n;
    logic [3:0]        op_q, op_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [31:0]       wdata_q, wdata_n;
    logic [31:0]       lo, lo_n, hi, hi_n;

    logic              accept;
    logic [2:0]        size;
    logic [1:0]        off;
    logic              is_store, invalid, misal, span, err_n;
    logic [WA_W-1:0]   w0, w1;
    logic [63:0]       cur, bit_mask, ins_data, merged, shifted;
    logic [7:0]        byte_en;
    logic [31:0]       size_mask, load_val;

    // The request as seen by this cycle's decode: live inputs on accept, else the captured copy.
    always_comb begin
        accept  = req_valid && (state == IDLE);
        op_n    = accept ? req_op    : op_q;
        addr_n  = accept ? req_addr  : addr_q;
        wdata_n = accept ? req_wdata : wdata_q;

        off      = addr_n[1:0];
        invalid  = op_n[3];
        is_store = (op_n == OP_SB) || (op_n == OP_SH) || (op_n == OP_SW);
        case (op_n)
            OP_LB, OP_LBU, OP_SB: size = 3'd1;
            OP_LH, OP_LHU, OP_SH: size = 3'd2;
            default:              size = 3'd4;
        endcase
        misal = ((size == 3'd2) && off[0]) || ((size == 3'd4) && (off != 2'd0));
        span  = (4'(off) + 4'(size)) > 4'd4;
        err_n = invalid || (misal && !MISALIGN_EN);
        w0    = addr_n[ADDR_W-1:2];
        w1    = w0 + WA_W'(1);
    end

    always_comb begin
        state_n = state;
        lo_n    = lo;
        hi_n    = hi;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    lo_n = 32'd0;
                    hi_n = 32'd0;
                    if (err_n)
                        state_n = RESP;
                    else if ((op_n == OP_SW) && (off == 2'd0))
                        state_n = WR0;
                    else
                        state_n = RD0;
                end
            end
            RD0: state_n = span ? RD1 : CAP;
            RD1: begin
                lo_n    = mem_rdata;
                state_n = CAP;
            end
            CAP: begin
                if (span)
                    hi_n = mem_rdata;
                else
                    lo_n = mem_rdata;
                state_n = is_store ? WR0 : RESP;
            end
            WR0:     state_n = span ? WR1 : RESP;
            WR1:     state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Store merge and load extraction over the two-word window {hi,lo}.
    always_comb begin
        cur       = {hi_n, lo_n};
        size_mask = (size == 3'd1) ? 32'h0000_00FF :
                    (size == 3'd2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        byte_en   = ((size == 3'd1) ? 8'h01 : (size == 3'd2) ? 8'h03 : 8'h0F) << off;
        for (int i = 0; i < 8; i++)
            bit_mask[i*8 +: 8] = {8{byte_en[i]}};
        ins_data  = 64'(wdata_n & size_mask) << {off, 3'b000};
        merged    = (cur & ~bit_mask) | ins_data;
        shifted   = cur >> {off, 3'b000};
        case (op_n)
            OP_LB:   load_val = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  load_val = {24'd0, shifted[7:0]};
            OP_LH:   load_val = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  load_val = {16'd0, shifted[15:0]};
            OP_LW:   load_val = shifted[31:0];
            default: load_val = 32'd0;
        endcase
    end

    // State, captured request and registered outputs decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            lo         <= 32'd0;
            hi         <= 32'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_wdata  <= 32'd0;
        end else begin
            state <= state_n;
            lo    <= lo_n;
            hi    <= hi_n;
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            req_ready  <= (state_n == IDLE);
            mem_re     <= (state_n == RD0) || (state_n == RD1);
            mem_we     <= (state_n == WR0) || (state_n == WR1);
            mem_addr   <= ((state_n == RD0) || (state_n == WR0)) ? w0 :
                          ((state_n == RD1) || (state_n == WR1)) ? w1 : '0;
            mem_wdata  <= (state_n == WR0) ? merged[31:0] :
                          (state_n == WR1) ? merged[63:32] : 32'd0;
            resp_valid <= (state_n == RESP);
            if (state_n == RESP) begin
                resp_rdata <= err_n ? 32'd0 : load_val;
                resp_err   <= err_n;
            end
        end
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// Self-checking bench for lsu_rmw: directed cases plus randomized requests against a
// byte-level memory reference model.
module tb_lsu_rmw;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [29:0] mem_addr;
    logic        mem_re, mem_we;
    logic [31:0] mem_rdata, mem_wdata;

    logic        na_req_valid, na_req_ready;
    logic [3:0]  na_req_op;
    logic [31:0] na_req_addr, na_req_wdata;
    logic        na_resp_valid, na_resp_err;
    logic [31:0] na_resp_rdata;
    logic [29:0] na_mem_addr;
    logic        na_mem_re, na_mem_we;
    logic [31:0] na_mem_rdata, na_mem_wdata;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    int          n_cmp, n_bad, both_hi;

    lsu_rmw #(.ADDR_W(32), .MISALIGN_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata)
    );

    lsu_rmw #(.ADDR_W(32), .MISALIGN_EN(1'b0)) dut_na (
        .clk(clk), .rst(rst),
        .req_valid(na_req_valid), .req_ready(na_req_ready), .req_op(na_req_op),
        .req_addr(na_req_addr), .req_wdata(na_req_wdata),
        .resp_valid(na_resp_valid), .resp_rdata(na_resp_rdata), .resp_err(na_resp_err),
        .mem_addr(na_mem_addr), .mem_re(na_mem_re), .mem_rdata(na_mem_rdata),
        .mem_we(na_mem_we), .mem_wdata(na_mem_wdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory; only 256 words are modelled, upper word-address bits alias.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end

    always @(negedge clk) if (mem_re && mem_we) both_hi++;

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [3:0] op);
        if (op == 0 || op == 3 || op == 5) return 1;
        if (op == 1 || op == 4 || op == 6) return 2;
        return 4;
    endfunction

    function automatic logic [7:0] rbyte(input logic [31:0] a);
        logic [31:0] w;
        w = ref_mem[a[9:2]];
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    task automatic wbyte(input logic [31:0] a, input logic [7:0] b);
        logic [31:0] w;
        w = ref_mem[a[9:2]];
        w[{a[1:0], 3'b000} +: 8] = b;
        ref_mem[a[9:2]] = w;
    endtask

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] a);
        logic [31:0] v;
        v = 0;
        for (int i = 0; i < op_size(op); i++)
            v = v | (32'(rbyte(a + 32'(i))) << (8 * i));
        if (op == 0 && v[7])  v = v | 32'hFFFF_FF00;
        if (op == 1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic model_store(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < op_size(op); i++)
            wbyte(a + 32'(i), wd[8*i +: 8]);
    endtask

    task automatic preload();
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = $urandom;
            mem[i]     = ref_mem[i];
        end
        ref_mem[0] = 32'h4433_2211; mem[0] = 32'h4433_2211;
        ref_mem[1] = 32'h8877_6655; mem[1] = 32'h8877_6655;
    endtask

    // ---------------- request driver ----------------
    task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int nre, output int nwe,
                          output logic [29:0] ra0, output logic [29:0] ra1,
                          output int rc0, output int rc1, output logic rv_after);
        int k;
        lat = -1; rd = 32'hXXXX_XXXX; er = 1'bx; nre = 0; nwe = 0;
        ra0 = 0; ra1 = 0; rc0 = -1; rc1 = -1; rv_after = 1'b0;
        @(negedge clk);
        k = 0;
        while (!req_ready && k < 20) begin @(negedge clk); k++; end
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge clk);
            if (mem_re) begin
                if (nre == 0) begin ra0 = mem_addr; rc0 = c; end
                else begin ra1 = mem_addr; rc1 = c; end
                nre++;
            end
            if (mem_we) nwe++;
            if (resp_valid) begin lat = c; rd = resp_rdata; er = resp_err; end
        end
        @(negedge clk);
        rv_after = resp_valid;
    endtask

    task automatic na_req(input logic [3:0] op, input logic [31:0] addr,
                          output int lat, output logic er, output logic [31:0] rd, output int nrw);
        lat = -1; er = 1'bx; rd = 32'hXXXX_XXXX; nrw = 0;
        @(negedge clk);
        na_req_valid = 1'b1; na_req_op = op; na_req_addr = addr; na_req_wdata = $urandom;
        @(posedge clk); #1;
        na_req_valid = 1'b0;
        for (int c = 1; c <= 10 && lat < 0; c++) begin
            @(negedge clk);
            if (na_mem_re || na_mem_we) nrw++;
            if (na_resp_valid) begin lat = c; er = na_resp_err; rd = na_resp_rdata; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        n_cmp++; if ({resp_valid, resp_err, mem_re, mem_we} !== 4'b0) begin
            n_bad++; $display("FAIL reset_strobes got=%b exp=0000", {resp_valid, resp_err, mem_re, mem_we}); end
        n_cmp++; if ({resp_rdata, mem_wdata} !== 64'd0 || mem_addr !== 30'd0) begin
            n_bad++; $display("FAIL reset_data rdata=%h wdata=%h addr=%h exp=0", resp_rdata, mem_wdata, mem_addr); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_re !== 1'b0) begin
            n_bad++; $display("FAIL post_reset ready=%b rv=%b re=%b exp=1/0/0", req_ready, resp_valid, mem_re); end
    endtask

    task automatic test_sub_word_loads();
        int lat, nre, nwe, rc0, rc1; logic [31:0] rd; logic er, rva; logic [29:0] ra0, ra1;
        preload();
        do_req(4'd0, 32'd3, 32'd0, lat, rd, er, nre, nwe, ra0, ra1, rc0, rc1, rva);
        n_cmp++; if (rd !== 32'h0000_0044 || lat !== 3 || er !== 1'b0) begin
            n_bad++; $display("FAIL lb3 got=%h lat=%0d err=%b exp=00000044 lat=3 err=0", rd, lat, er); end
        do_req(4'd0, 32'd7, 32'd0, lat, rd, er, nre, nwe, ra0, ra1, rc0, rc1, rva);
        n_cmp++; if (rd !== 32'hFFFF_FF88 || lat !== 3) begin
            n_bad++; $display("FAIL lb7 got=%h lat=%0d exp=ffffff88 lat=3", rd, lat); end
        do_req(4'd4, 32'd1, 32'd0, lat, rd, er, nre, nwe, ra0, ra1, rc0, rc1, rva);
        n_cmp++; if (rd !== 32'h0000_3322 || nre !== 1 || lat !== 3) begin
            n_bad++; $display("FAIL lhu1 got=%h reads=%0d lat=%0d exp=00003322 reads=1 lat=3", rd, nre, lat); end
        n_cmp++; if (rva !== 1'b0) begin n_bad++; $display("FAIL resp_one_cycle got=%b exp=0", rva); end
    endtask

    task automatic test_spanning_load();
        int lat, nre, nwe, rc0, rc1; logic [31:0] rd; logic er, rva; logic [29:0] ra0, ra1;
        preload();
        do_req(4'd2, 32'd1, 32'd0, lat, rd, er, nre, nwe, ra0, ra1, rc0, rc1, rva);
        n_cmp++; if (rd !== 32'h5544_3322 || lat !== 4) begin
            n_bad++; $display("FAIL lw1 got=%h lat=%0d exp=55443322 lat=4", rd, lat); end
        n_cmp++; if (nre !== 2 || ra0 !== 30'd0 || ra1 !== 30'd1 || rc1 !== rc0 + 1) begin
            n_bad++; $display("FAIL lw1_reads n=%0d a0=%h a1=%h c0=%0d c1=%0d exp=2,0,1,consecutive", nre, ra0, ra1, rc0, rc1); end
    endtask

    task automatic test_stores();
        int lat, nre, nwe, rc0, rc1; logic [31:0] rd; logic er, rva; logic [29:0] ra0, ra1;
        preload();
        do_req(4'd6, 32'd3, 32'h1234_BEEF, lat, rd, er, nre, nwe, ra0, ra1, rc0, rc1, rva);
        n_cmp++; if (mem[0] !== 32'hEF33_2211 || mem[1] !== 32'h8877_66BE) begin
            n_bad++; $display("FAIL sh3_mem got=%h,%h exp=ef332211,887766be", mem[0], mem[1]); end
        n_cmp++; if (nwe !== 2 || lat !== 6 || rd !== 32'd0 || er !== 1'b0) begin
            n_bad++; $display("FAIL sh3_resp writes=%0d lat=%0d rdata=%h err=%b exp=2,6,0,0", nwe, lat, rd, er); end
        preload();
        do_req(4'd7, 32'd4, 32'hDEAD_BEEF, lat, rd, er, nre, nwe, ra0, ra1, rc0, rc1, rva);
        n_cmp++; if (mem[1] !== 32'hDEAD_BEEF || mem[0] !== 32'h4433_2211) begin
            n_bad++; $display("FAIL sw4_mem got=%h,%h exp=44332211,deadbeef", mem[0], mem[1]); end
        n_cmp++; if (nre !== 0 || nwe !== 1 || lat !== 2) begin
            n_bad++; $display("FAIL sw4_resp reads=%0d writes=%0d lat=%0d exp=0,1,2", nre, nwe, lat); end
    endtask

    task automatic test_errors();
        int lat, nre, nwe, rc0, rc1, nrw; logic [31:0] rd; logic er, rva; logic [29:0] ra0, ra1;
        do_req(4'hF, 32'd0, 32'd0, lat, rd, er, nre, nwe, ra0, ra1, rc0, rc1, rva);
        n_cmp++; if (er !== 1'b1 || rd !== 32'd0 || lat !== 1 || nre + nwe !== 0) begin
            n_bad++; $display("FAIL bad_op err=%b rdata=%h lat=%0d mem=%0d exp=1,0,1,0", er, rd, lat, nre + nwe); end
        na_req(4'd2, 32'd2, lat, er, rd, nrw);
        n_cmp++; if (er !== 1'b1 || rd !== 32'd0 || lat !== 1 || nrw !== 0) begin
            n_bad++; $display("FAIL na_lw2 err=%b rdata=%h lat=%0d mem=%0d exp=1,0,1,0", er, rd, lat, nrw); end
        na_req(4'd0, 32'd3, lat, er, rd, nrw);
        n_cmp++; if (er !== 1'b0 || lat !== 3 || nrw !== 1) begin
            n_bad++; $display("FAIL na_lb3 err=%b lat=%0d mem=%0d exp=0,3,1", er, lat, nrw); end
    endtask

    task automatic test_wrap();
        int lat, nre, nwe, rc0, rc1; logic [31:0] rd, exp; logic er, rva; logic [29:0] ra0, ra1;
        preload();
        exp = model_load(4'd1, 32'hFFFF_FFFF);
        do_req(4'd1, 32'hFFFF_FFFF, 32'd0, lat, rd, er, nre, nwe, ra0, ra1, rc0, rc1, rva);
        n_cmp++; if (nre !== 2 || ra0 !== 30'h3FFF_FFFF || ra1 !== 30'd0) begin
            n_bad++; $display("FAIL wrap_addr n=%0d a0=%h a1=%h exp=2,3fffffff,0", nre, ra0, ra1); end
        n_cmp++; if (rd !== exp || lat !== 4) begin
            n_bad++; $display("FAIL wrap_data got=%h lat=%0d exp=%h lat=4", rd, lat, exp); end
    endtask

    task automatic test_reset_mid();
        int rv, lat, nre, nwe, rc0, rc1; logic [31:0] rd; logic er, rva; logic [29:0] ra0, ra1;
        preload();
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd7; req_addr = 32'd1; req_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 30'd1) begin
            n_bad++; $display("FAIL wr1_reached we=%b addr=%h exp=1,1", mem_we, mem_addr); end
        rst = 1'b1;
        #1;
        n_cmp++; if (mem_we !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_bad++; $display("FAIL abort we=%b ready=%b rv=%b exp=0,1,0", mem_we, req_ready, resp_valid); end
        n_cmp++; if (mem[0] !== 32'hFEF0_0D11 || mem[1] !== 32'h8877_6655) begin
            n_bad++; $display("FAIL abort_mem got=%h,%h exp=fef00d11,88776655", mem[0], mem[1]); end
        @(negedge clk);
        rst = 1'b0;
        rv = 0;
        repeat (4) begin @(negedge clk); if (resp_valid) rv++; end
        n_cmp++; if (rv !== 0) begin n_bad++; $display("FAIL abort_noresp got=%0d exp=0", rv); end
        do_req(4'd2, 32'd0, 32'd0, lat, rd, er, nre, nwe, ra0, ra1, rc0, rc1, rva);
        n_cmp++; if (rd !== 32'hFEF0_0D11 || lat !== 3) begin
            n_bad++; $display("FAIL after_abort got=%h lat=%0d exp=fef00d11 lat=3", rd, lat); end
    endtask

    task automatic test_random();
        int lat, nre, nwe, rc0, rc1, e_lat, e_nre, e_nwe, sz, bad_words;
        logic [31:0] rd, addr, wd, e_rd; logic er, rva, e_err, sp, st; logic [29:0] ra0, ra1;
        logic [3:0] op;
        preload();
        for (int it = 0; it < 60; it++) begin
            op   = ($urandom_range(0, 9) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
            addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                                : 32'($urandom_range(0, 1023));
            wd   = $urandom;
            sz   = op_size(op);
            sp   = (int'(addr[1:0]) + sz) > 4;
            st   = (op >= 5 && op <= 7);
            e_err = (op > 7);
            e_rd  = (e_err || st) ? 32'd0 : model_load(op, addr);
            if (e_err)                         begin e_lat = 1; e_nre = 0; e_nwe = 0; end
            else if (op == 7 && addr[1:0] == 0) begin e_lat = 2; e_nre = 0; e_nwe = 1; end
            else if (st) begin e_lat = sp ? 6 : 4; e_nre = sp ? 2 : 1; e_nwe = sp ? 2 : 1; end
            else         begin e_lat = sp ? 4 : 3; e_nre = sp ? 2 : 1; e_nwe = 0; end
            if (st) model_store(op, addr, wd);
            do_req(op, addr, wd, lat, rd, er, nre, nwe, ra0, ra1, rc0, rc1, rva);
            n_cmp++; if (rd !== e_rd || er !== e_err || lat !== e_lat) begin
                n_bad++; $display("FAIL rand_resp op=%0d addr=%h got=%h/%b/%0d exp=%h/%b/%0d", op, addr, rd, er, lat, e_rd, e_err, e_lat); end
            n_cmp++; if (nre !== e_nre || nwe !== e_nwe || rva !== 1'b0) begin
                n_bad++; $display("FAIL rand_mem op=%0d addr=%h re=%0d we=%0d rv_after=%b exp=%0d,%0d,0", op, addr, nre, nwe, rva, e_nre, e_nwe); end
        end
        bad_words = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad_words++;
        n_cmp++; if (bad_words !== 0) begin n_bad++; $display("FAIL rand_memory got=%0d wrong words exp=0", bad_words); end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0;
        n_cmp = 0; n_bad = 0; both_hi = 0;
        req_valid = 1'b0; req_op = 4'd0; req_addr = 32'd0; req_wdata = 32'd0;
        na_req_valid = 1'b0; na_req_op = 4'd0; na_req_addr = 32'd0; na_req_wdata = 32'd0;
        na_mem_rdata = 32'd0;
        preload();
        test_reset();
        test_sub_word_loads();
        test_spanning_load();
        test_stores();
        test_errors();
        test_wrap();
        test_reset_mid();
        test_random();
        n_cmp++; if (both_hi !== 0) begin n_bad++; $display("FAIL re_we_overlap got=%0d exp=0", both_hi); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
